dldo_switch_ctrl: RTL and testbench
===================================

Name: dldo_switch_ctrl

Overview:
Downstream stage of the LDO mode FSM. It consumes the one-hot loop-mode signals (coarse/medium/fine/steady) and the output-voltage comparator result. It drives the digital LDO power-switch array as a binary code plus a thermometer vector. Each loop mode updates the code with its own step size, paced by a settle counter. The block also detects limit cycling in fine mode and dithers the LSB in steady state.

Parameters:
N_SW, 64, number of power switches; maximum code value
CODE_W, 7, code width; must hold 0..N_SW
RESET_CODE, 32, switch code after reset
STEP_C, 8, coarse-loop step
STEP_M, 4, medium-loop step
STEP_F, 1, fine-loop step
SETTLE, 2, idle cycles between successive code updates
LC_COUNT, 4, consecutive direction reversals in fine mode that assert lc_detect

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
coarse_loop  in  1  coarse mode from LDO FSM
medium_loop  in  1  medium mode
fine_loop  in  1  fine mode
steady_state  in  1  steady/dither mode
cmp_up  in  1  1 = Vout below Vref, more switches needed; 0 = fewer
sw_code  out  CODE_W  active switch count, 0..N_SW
sw_therm  out  N_SW  thermometer: bit i = (i < sw_code)
sat_hi  out  1  sw_code == N_SW
sat_lo  out  1  sw_code == 0
lc_detect  out  1  fine-mode limit cycle detected; usable as dither_enable source

Behaviour:
- Reset (sampled on clk edge while rst=1), applied to all state:
  - code = RESET_CODE, lock_code = 0, dither = 0
  - settle cnt = 0, mode_q = NONE, dir_q = 0, rev_cnt = 0, lc_detect = 0
  - Resulting outputs: sw_code = RESET_CODE, sat_hi = 0, sat_lo = 0 (for defaults).
- rst takes priority over all other inputs, including mid-update.
- Effective mode (mode_eff) uses priority coarse > medium > fine > steady. If none is asserted, mode_eff = NONE.
- States (mode_q, registered mode_eff): NONE, COARSE, MEDIUM, FINE, STEADY.
- Update tick = loop mode (C/M/F) active AND (cnt == 0 OR mode_eff != mode_q).
  - A mode change therefore updates on its first cycle.
- On a tick:
  - code <= cmp_up ? min(code+step, N_SW) : max(code-step, 0), where step is chosen by mode.
  - Arithmetic is done at CODE_W+1 bits, with no wrap.
  - cnt <= SETTLE.
- Otherwise, cnt decrements while > 0. Ticks in a steady mode are therefore SETTLE+1 cycles apart.
- Output latency: sw_code, sw_therm and flags are driven from registers and change in the cycle after the tick edge. There is no combinational path from the inputs.
- FINE mode, limit-cycle detection:
  - At each tick, if cmp_up != dir_q, rev_cnt increments (saturating); else rev_cnt = 0. Then dir_q <= cmp_up.
  - lc_detect = 1 when rev_cnt reaches LC_COUNT. It stays sticky while in FINE.
  - Leaving FINE clears rev_cnt and lc_detect.
  - The first FINE tick after entry only loads dir_q and counts nothing.
- STEADY mode:
  - On entry (mode_eff == STEADY, mode_q != STEADY): lock_code <= code, dither <= 0, cnt <= SETTLE.
  - Each subsequent cnt == 0 cycle: dither toggles and cnt <= SETTLE.
  - sw_code = min(lock_code + dither, N_SW). code itself stays unchanged.
- Leaving STEADY: dither <= 0, and sw_code returns to code (= lock_code). The new mode ticks in the same cycle.
- NONE: code holds; cnt decrements to 0; dither = 0.
- Saturation:
  - At N_SW with cmp_up=1, or at 0 with cmp_up=0: code holds, and the tick still reloads cnt.
  - sat_hi and sat_lo reflect sw_code.
- Simultaneous events:
  - Multiple modes: priority as above.
  - Mode change coinciding with cnt == 0: a single update using the new mode's step.

Test Plan:
- Reset: rst=1 for 2 cycles, then release -> sw_code=32, sw_therm=0x0000_0000_FFFF_FFFF, sat_hi=sat_lo=lc_detect=0.
- Coarse up: from 32, coarse_loop=1, cmp_up=1 -> sw_code 40 on the next cycle, then 48, 56, 64 every 3 cycles. Then holds at 64 with sat_hi=1 and sw_therm all ones.
- Medium down saturation: code 6, medium_loop=1, cmp_up=0 -> 2, then 0 (clamped, no wrap to 124), sat_lo=1, sw_therm=0.
- Fine limit cycle: from 32, fine_loop=1, cmp_up toggling at each tick -> 33, 32, 33, 32, 33, ...; lc_detect rises after the 4th reversal. Deasserting fine_loop -> lc_detect=0 the next cycle.
- Steady dither and exit: code 33, steady_state=1 -> sw_code 33, then 34, 33, 34 every 3 cycles. Switching to fine with cmp_up=1 while sw_code=34 -> sw_code=34 via code 33+1, with dither cleared.
- Priority and reset mid-op: coarse_loop=fine_loop=1 with cmp_up=1 from 32 -> 40 (step 8). Asserting rst during the settle count -> sw_code=32 the next cycle, and the first post-reset coarse tick occurs immediately.

Source files
------------

// File: rtl/dldo_switch_ctrl.sv
// Digital LDO power-switch controller: per-mode stepped code updates paced by a
// settle counter, fine-mode limit-cycle detection and steady-state LSB dither.
module dldo_switch_ctrl #(
    parameter int N_SW       = 64,
    parameter int CODE_W     = 7,
    parameter int RESET_CODE = 32,
    parameter int STEP_C     = 8,
    parameter int STEP_M     = 4,
    parameter int STEP_F     = 1,
    parameter int SETTLE     = 2,
    parameter int LC_COUNT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coarse_loop,
    input  logic              medium_loop,
    input  logic              fine_loop,
    input  logic              steady_state,
    input  logic              cmp_up,
    output logic [CODE_W-1:0] sw_code,
    output logic [N_SW-1:0]   sw_therm,
    output logic              sat_hi,
    output logic              sat_lo,
    output logic              lc_detect
);
    localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int REV_W = (LC_COUNT < 1) ? 1 : $clog2(LC_COUNT + 1);
    localparam logic [CODE_W:0] NSW_X = (CODE_W+1)'(N_SW);

    typedef enum logic [2:0] {M_NONE, M_COARSE, M_MEDIUM, M_FINE, M_STEADY} mode_e;

    mode_e             mode_q, mode_eff;
    logic [CODE_W-1:0] code_q, code_d, lock_q, lock_d, sw_code_q, sw_code_d;
    logic              dither_q, dither_d, dir_q, dir_d, lc_q, lc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic [N_SW-1:0]   sw_therm_q, sw_therm_d;
    logic              sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
    logic              loop_act, chg, tick;
    logic [CODE_W:0]   step, sum, diff, lsum;

    function automatic logic [N_SW-1:0] therm_of(input logic [CODE_W-1:0] c);
        logic [N_SW-1:0] t;
        for (int i = 0; i < N_SW; i++) t[i] = (i < int'(c));
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= M_NONE;
            code_q     <= CODE_W'(RESET_CODE);
            lock_q     <= '0;
            dither_q   <= 1'b0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            rev_q      <= '0;
            lc_q       <= 1'b0;
            sw_code_q  <= CODE_W'(RESET_CODE);
            sw_therm_q <= therm_of(CODE_W'(RESET_CODE));
            sat_hi_q   <= (RESET_CODE == N_SW);
            sat_lo_q   <= (RESET_CODE == 0);
        end else begin
            mode_q     <= mode_eff;
            code_q     <= code_d;
            lock_q     <= lock_d;
            dither_q   <= dither_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            rev_q      <= rev_d;
            lc_q       <= lc_d;
            sw_code_q  <= sw_code_d;
            sw_therm_q <= sw_therm_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
        end
    end

    always_comb begin
        mode_eff = M_NONE;
        if (coarse_loop)       mode_eff = M_COARSE;
        else if (medium_loop)  mode_eff = M_MEDIUM;
        else if (fine_loop)    mode_eff = M_FINE;
        else if (steady_state) mode_eff = M_STEADY;
    end

    always_comb begin
        code_d   = code_q;
        lock_d   = lock_q;
        dither_d = dither_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        rev_d    = rev_q;
        lc_d     = lc_q;
        loop_act = (mode_eff == M_COARSE) || (mode_eff == M_MEDIUM) || (mode_eff == M_FINE);
        chg      = (mode_eff != mode_q);
        tick     = loop_act && ((cnt_q == '0) || chg);
        case (mode_eff)
            M_COARSE: step = (CODE_W+1)'(STEP_C);
            M_MEDIUM: step = (CODE_W+1)'(STEP_M);
            default:  step = (CODE_W+1)'(STEP_F);
        endcase
        sum  = {1'b0, code_q} + step;
        diff = {1'b0, code_q} - step;
        if (tick) begin
            // A borrow into the extra bit means the subtraction went negative.
            if (cmp_up) code_d = (sum > NSW_X) ? NSW_X[CODE_W-1:0] : sum[CODE_W-1:0];
            else        code_d = diff[CODE_W] ? '0 : diff[CODE_W-1:0];
            cnt_d = CNT_W'(SETTLE);
            if (mode_eff == M_FINE) begin
                if (mode_q == M_FINE) begin
                    if (cmp_up != dir_q)
                        rev_d = (rev_q == REV_W'(LC_COUNT)) ? rev_q : rev_q + 1'b1;
                    else
                        rev_d = '0;
                end
                dir_d = cmp_up;
            end
        end else if (mode_eff == M_STEADY) begin
            if (chg) begin
                lock_d   = code_q;
                dither_d = 1'b0;
                cnt_d    = CNT_W'(SETTLE);
            end else if (cnt_q == '0) begin
                dither_d = ~dither_q;
                cnt_d    = CNT_W'(SETTLE);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (mode_eff != M_STEADY) dither_d = 1'b0;
        if (mode_eff == M_FINE) begin
            lc_d = lc_q || (rev_d == REV_W'(LC_COUNT));
        end else begin
            rev_d = '0;
            lc_d  = 1'b0;
        end
    end

    // Outputs are precomputed from next state so they leave the block registered.
    always_comb begin
        lsum = {1'b0, lock_d} + (CODE_W+1)'(dither_d);
        if (mode_eff == M_STEADY) sw_code_d = (lsum > NSW_X) ? NSW_X[CODE_W-1:0] : lsum[CODE_W-1:0];
        else                      sw_code_d = code_d;
        sw_therm_d = therm_of(sw_code_d);
        sat_hi_d   = ({1'b0, sw_code_d} == NSW_X);
        sat_lo_d   = (sw_code_d == '0);
    end

    assign sw_code   = sw_code_q;
    assign sw_therm  = sw_therm_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign lc_detect = lc_q;
endmodule

// File: tb/tb_dldo_switch_ctrl.sv
// Bench for dldo_switch_ctrl: vector table, directed corner sequences and a
// random run checked every cycle against an integer reference model.
module tb_dldo_switch_ctrl;
    localparam int N_SW = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coarse_loop = 1'b0, medium_loop = 1'b0, fine_loop = 1'b0, steady_state = 1'b0;
    logic        cmp_up = 1'b0;
    logic [6:0]  sw_code;
    logic [63:0] sw_therm;
    logic        sat_hi, sat_lo, lc_detect;

    int total = 0;
    int bad   = 0;

    dldo_switch_ctrl dut (
        .clk(clk), .rst(rst), .coarse_loop(coarse_loop), .medium_loop(medium_loop),
        .fine_loop(fine_loop), .steady_state(steady_state), .cmp_up(cmp_up),
        .sw_code(sw_code), .sw_therm(sw_therm), .sat_hi(sat_hi), .sat_lo(sat_lo),
        .lc_detect(lc_detect)
    );

    always #5 clk = ~clk;

    // Reference model: mode numbers 0 none, 1 coarse, 2 medium, 3 fine, 4 steady.
    int m_code, m_lock, m_dith, m_cnt, m_mode, m_dir, m_rev, m_lc;

    function automatic int m_out();
        if (m_mode == 4) return (m_lock + m_dith > N_SW) ? N_SW : m_lock + m_dith;
        return m_code;
    endfunction

    task automatic model_step(input logic r, c, m, f, s, up);
        int me, st;
        if (r) begin
            m_code = 32; m_lock = 0; m_dith = 0; m_cnt = 0;
            m_mode = 0; m_dir = 0; m_rev = 0; m_lc = 0;
            return;
        end
        me = c ? 1 : m ? 2 : f ? 3 : s ? 4 : 0;
        if (me >= 1 && me <= 3 && (m_cnt == 0 || me != m_mode)) begin
            st = (me == 1) ? 8 : (me == 2) ? 4 : 1;
            if (up) m_code = (m_code + st > N_SW) ? N_SW : m_code + st;
            else    m_code = (m_code - st < 0) ? 0 : m_code - st;
            if (me == 3) begin
                if (m_mode == 3) m_rev = (int'(up) != m_dir) ? ((m_rev < 4) ? m_rev + 1 : 4) : 0;
                m_dir = int'(up);
            end
            m_cnt = 2;
        end else if (me == 4) begin
            if (me != m_mode) begin m_lock = m_code; m_dith = 0; m_cnt = 2; end
            else if (m_cnt == 0) begin m_dith = 1 - m_dith; m_cnt = 2; end
            else m_cnt--;
        end else if (m_cnt > 0) m_cnt--;
        if (me != 4) m_dith = 0;
        if (me == 3) m_lc = (m_lc != 0 || m_rev >= 4) ? 1 : 0;
        else begin m_rev = 0; m_lc = 0; end
        m_mode = me;
    endtask

    function automatic logic [63:0] therm_ref(input int c);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < c; i++) t[i] = 1'b1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic r, c, m, f, s, up);
        int e;
        rst = r; coarse_loop = c; medium_loop = m; fine_loop = f; steady_state = s; cmp_up = up;
        @(posedge clk);
        model_step(r, c, m, f, s, up);
        #1;
        e = m_out();
        chk("model_code", 64'(sw_code), 64'(e));
        chk("model_therm", sw_therm, therm_ref(e));
        chk("model_sat_hi", 64'(sat_hi), 64'(e == N_SW));
        chk("model_sat_lo", 64'(sat_lo), 64'(e == 0));
        chk("model_lc", 64'(lc_detect), 64'(m_lc));
    endtask

    task automatic run(input logic c, m, f, s, up, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, c, m, f, s, up);
    endtask

    typedef struct {
        logic r, c, m, f, s, up;
        int   code;
        logic hi, lo, lc;
    } vec_t;

    vec_t tbl[20];

    task automatic setv(input int i, input logic r, c, m, f, s, up, input int code);
        tbl[i].r = r; tbl[i].c = c; tbl[i].m = m; tbl[i].f = f; tbl[i].s = s; tbl[i].up = up;
        tbl[i].code = code; tbl[i].hi = (code == 64); tbl[i].lo = (code == 0); tbl[i].lc = 1'b0;
    endtask

    initial begin
        int hold, mode, k;
        logic [3:0] rb;
        logic lastup;
        // reset, coarse ramp to saturation, priority, reset mid-settle
        setv(0, 1,0,0,0,0,0, 32); setv(1, 1,0,0,0,0,0, 32);
        setv(2, 0,1,0,0,0,1, 40); setv(3, 0,1,0,0,0,1, 40); setv(4, 0,1,0,0,0,1, 40);
        setv(5, 0,1,0,0,0,1, 48); setv(6, 0,1,0,0,0,1, 48); setv(7, 0,1,0,0,0,1, 48);
        setv(8, 0,1,0,0,0,1, 56); setv(9, 0,1,0,0,0,1, 56); setv(10,0,1,0,0,0,1, 56);
        setv(11,0,1,0,0,0,1, 64); setv(12,0,1,0,0,0,1, 64); setv(13,0,1,0,0,0,1, 64);
        setv(14,0,1,0,0,0,1, 64);
        setv(15,1,0,0,0,0,0, 32); setv(16,0,1,0,1,0,1, 40); setv(17,0,1,0,1,0,1, 40);
        setv(18,1,1,0,1,0,1, 32); setv(19,0,1,0,0,0,1, 40);
        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].r, tbl[i].c, tbl[i].m, tbl[i].f, tbl[i].s, tbl[i].up);
            chk($sformatf("tbl%0d_code", i), 64'(sw_code), 64'(tbl[i].code));
            chk($sformatf("tbl%0d_therm", i), sw_therm, therm_ref(tbl[i].code));
            chk($sformatf("tbl%0d_hi", i), 64'(sat_hi), 64'(tbl[i].hi));
            chk($sformatf("tbl%0d_lo", i), 64'(sat_lo), 64'(tbl[i].lo));
            chk($sformatf("tbl%0d_lc", i), 64'(lc_detect), 64'(tbl[i].lc));
        end

        // medium-down clamp at zero: 32 -> 8 (coarse) -> 6 (fine) -> 2, 0 (medium)
        cyc(1,0,0,0,0,0);
        run(1,0,0,0,0, 7);
        run(0,0,1,0,0, 4);
        chk("med_start6", 64'(sw_code), 64'd6);
        run(0,1,0,0,0, 1);
        chk("med_first2", 64'(sw_code), 64'd2);
        run(0,1,0,0,0, 6);
        chk("med_clamp0", 64'(sw_code), 64'd0);
        chk("med_sat_lo", 64'(sat_lo), 64'd1);
        chk("med_therm0", sw_therm, 64'd0);

        // fine limit cycle
        cyc(1,0,0,0,0,0);
        for (k = 0; k < 7; k++) begin
            run(0,0,1,0, (k % 2 == 0), 3);
            if (k == 3) chk("lc_before_4th_rev", 64'(lc_detect), 64'd0);
        end
        chk("lc_sticky", 64'(lc_detect), 64'd1);
        chk("lc_code", 64'(sw_code), 64'd33);
        run(0,0,0,0,0, 1);
        chk("lc_clear", 64'(lc_detect), 64'd0);

        // steady dither and exit into fine
        cyc(1,0,0,0,0,0);
        run(0,0,1,0,1, 1);
        run(0,0,0,1,0, 1);
        chk("steady_entry", 64'(sw_code), 64'd33);
        run(0,0,0,1,0, 3);
        chk("steady_dither1", 64'(sw_code), 64'd34);
        run(0,0,0,1,0, 3);
        chk("steady_dither0", 64'(sw_code), 64'd33);
        run(0,0,0,1,0, 3);
        chk("steady_dither1b", 64'(sw_code), 64'd34);
        run(0,0,1,0,1, 1);
        chk("steady_exit_fine", 64'(sw_code), 64'd34);
        run(0,0,1,0,1, 3);
        chk("post_exit_tick", 64'(sw_code), 64'd35);

        // randomized run against the model
        hold = 0; mode = 0; lastup = 1'b0; rb = '0;
        for (int n = 0; n < 3000; n++) begin
            logic up, r;
            if (hold == 0) begin
                mode = $urandom_range(0, 5);
                rb   = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 14);
            end
            hold--;
            up = (mode == 3 && $urandom_range(0, 3) != 0) ? ~lastup : 1'($urandom_range(0, 1));
            lastup = up;
            r = ($urandom_range(0, 299) == 0);
            if (mode == 5) cyc(r, rb[0], rb[1], rb[2], rb[3], up);
            else cyc(r, mode == 1, mode == 2, mode == 3, mode == 4, up);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
